// File: rtl/ram_8kx32_arbiter_if.sv
// Bus bundle between two requesting ports, the arbiter and a single-port 8Kx32 RAM.
// The arbiter sits on the slave modport; the ports and the RAM model sit on the master side.
interface ram_8kx32_arbiter_if;
  logic        P0_REQ;
  logic        P0_LOCK;
  logic [3:0]  P0_WE;
  logic [12:0] P0_A;
  logic [31:0] P0_Di;
  logic        P0_GNT;
  logic        P0_DV;
  logic [31:0] P0_Do;

  logic        P1_REQ;
  logic        P1_LOCK;
  logic [3:0]  P1_WE;
  logic [12:0] P1_A;
  logic [31:0] P1_Di;
  logic        P1_GNT;
  logic        P1_DV;
  logic [31:0] P1_Do;

  logic        RAM_EN;
  logic [3:0]  RAM_WE;
  logic [12:0] RAM_A;
  logic [31:0] RAM_Di;
  logic [31:0] RAM_Do;

  modport slave (
    input  P0_REQ, P0_LOCK, P0_WE, P0_A, P0_Di,
    input  P1_REQ, P1_LOCK, P1_WE, P1_A, P1_Di,
    input  RAM_Do,
    output P0_GNT, P0_DV, P0_Do,
    output P1_GNT, P1_DV, P1_Do,
    output RAM_EN, RAM_WE, RAM_A, RAM_Di
  );

  modport master (
    output P0_REQ, P0_LOCK, P0_WE, P0_A, P0_Di,
    output P1_REQ, P1_LOCK, P1_WE, P1_A, P1_Di,
    output RAM_Do,
    input  P0_GNT, P0_DV, P0_Do,
    input  P1_GNT, P1_DV, P1_Do,
    input  RAM_EN, RAM_WE, RAM_A, RAM_Di
  );
endinterface

// File: rtl/ram_8kx32_arbiter.sv
// Two-port arbiter for one 8Kx32 RAM: alternating priority on ties, optional lock ownership.
// Define ARB_LOCK_TIMEOUT_EN to force a locked port back to IDLE after LOCK_MAX grants.
module ram_8kx32_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  ram_8kx32_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;   // 1: port 1 was granted most recently
  logic   dv0_q, dv0_d;
  logic   dv1_q, dv1_d;
  logic   gnt0, gnt1;
  logic   lock_expired;

`ifdef ARB_LOCK_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // The grant that took the lock counts as the first; the LOCK_MAX-th one releases it.
  assign lock_expired = (state_q != IDLE) && (cnt_q == 8'(LOCK_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == IDLE)  cnt_d = 8'd0;
    else if (gnt0 || gnt1) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end
`else
  assign lock_expired = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.P0_REQ && bus.P1_REQ) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else begin
          gnt0 = bus.P0_REQ;
          gnt1 = bus.P1_REQ;
        end
        if (gnt0 && bus.P0_LOCK)      state_d = OWN0;
        else if (gnt1 && bus.P1_LOCK) state_d = OWN1;
      end
      OWN0: begin
        gnt0 = bus.P0_REQ;
        if (!bus.P0_REQ || !bus.P0_LOCK || lock_expired) state_d = IDLE;
      end
      OWN1: begin
        gnt1 = bus.P1_REQ;
        if (!bus.P1_REQ || !bus.P1_LOCK || lock_expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Grants are combinational, so they must be forced low while reset is held.
    if (!RESETn) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    if (gnt0)      last_d = 1'b0;
    else if (gnt1) last_d = 1'b1;
  end

  assign dv0_d = gnt0 && (bus.P0_WE == 4'b0000);
  assign dv1_d = gnt1 && (bus.P1_WE == 4'b0000);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      dv0_q   <= 1'b0;
      dv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      dv0_q   <= dv0_d;
      dv1_q   <= dv1_d;
    end
  end

  assign bus.P0_GNT = gnt0;
  assign bus.P1_GNT = gnt1;
  assign bus.P0_DV  = dv0_q;
  assign bus.P1_DV  = dv1_q;
  assign bus.P0_Do  = bus.RAM_Do;
  assign bus.P1_Do  = bus.RAM_Do;

  assign bus.RAM_EN = gnt0 || gnt1;
  assign bus.RAM_WE = gnt0 ? bus.P0_WE : (gnt1 ? bus.P1_WE : 4'b0000);
  assign bus.RAM_A  = gnt1 ? bus.P1_A  : bus.P0_A;
  assign bus.RAM_Di = gnt1 ? bus.P1_Di : bus.P0_Di;

endmodule

// File: tb/tb_ram_8kx32_arbiter.sv
// Self-checking bench for ram_8kx32_arbiter: directed vector table, lock/timeout/reset
// sequences and randomized traffic against a transaction-level reference model.
module tb_ram_8kx32_arbiter;
  localparam int LockMax = 4;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic [3:0]  we;
    logic [12:0] a;
    logic [31:0] di;
  } port_t;

  typedef struct {
    port_t       p0;
    port_t       p1;
    bit          eg0;
    bit          eg1;
    int          edv_port;   // -1: no DV expected this cycle
    logic [31:0] edo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_8kx32_arbiter_if bus ();

  ram_8kx32_arbiter #(.LOCK_MAX(LockMax)) dut (
    .CLK    (clk),
    .RESETn (rst_n),
    .bus    (bus)
  );

  // Synchronous 8Kx32 RAM with byte enables.
  logic [31:0] ram_mem [8192];
  always @(posedge clk) begin
    if (bus.RAM_EN) begin
      if (bus.RAM_WE == 4'b0000) bus.RAM_Do <= ram_mem[bus.RAM_A];
      else
        for (int b = 0; b < 4; b++)
          if (bus.RAM_WE[b]) ram_mem[bus.RAM_A][8*b +: 8] <= bus.RAM_Di[8*b +: 8];
    end
  end

  // Reference model: owner (-1 = nobody), last granted port, lock grant count, pending reads.
  logic [31:0] exp_mem [8192];
  int          owner;
  int          last;
  int          cnt;
  bit          pend [2];
  logic [31:0] pend_do [2];

  int n_checks = 0;
  int n_err    = 0;
  bit act_g0, act_g1, act_dv0, act_dv1;
  logic [31:0] act_do0, act_do1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic port_t mkp(input bit req, input bit lock, input logic [3:0] we,
                                input logic [12:0] a, input logic [31:0] di);
    port_t p;
    p.req = req; p.lock = lock; p.we = we; p.a = a; p.di = di;
    return p;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE0000 + 32'(i);
  endfunction

  function automatic int model_grant(input bit r0, input bit r1);
    if (owner >= 0) return ((owner == 0 ? r0 : r1) ? owner : -1);
    if (r0 && r1)   return (last == 0) ? 1 : 0;
    if (r0)         return 0;
    if (r1)         return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; last = 1; cnt = 0;
    pend[0] = 0; pend[1] = 0;
  endtask

  task automatic model_update(input int g, input port_t p0, input port_t p1);
    port_t pg, own;
    pg = '0;
    pend[0] = 0; pend[1] = 0;
    if (g >= 0) begin
      pg = (g == 1) ? p1 : p0;
      last = g;
      if (pg.we == 4'b0000) begin
        pend[g] = 1;
        pend_do[g] = exp_mem[pg.a];
      end else begin
        for (int b = 0; b < 4; b++)
          if (pg.we[b]) exp_mem[pg.a][8*b +: 8] = pg.di[8*b +: 8];
      end
    end
    if (owner < 0) begin
      if (g >= 0 && pg.lock) begin owner = g; cnt = 1; end
    end else begin
      own = (owner == 0) ? p0 : p1;
      if (!own.req || !own.lock) owner = -1;
      else begin
        cnt++;
`ifdef ARB_LOCK_TIMEOUT_EN
        if (cnt >= LockMax) owner = -1;
`endif
      end
    end
    if (owner < 0) cnt = 0;
  endtask

  task automatic drive(input port_t p0, input port_t p1);
    bus.P0_REQ = p0.req; bus.P0_LOCK = p0.lock; bus.P0_WE = p0.we; bus.P0_A = p0.a; bus.P0_Di = p0.di;
    bus.P1_REQ = p1.req; bus.P1_LOCK = p1.lock; bus.P1_WE = p1.we; bus.P1_A = p1.a; bus.P1_Di = p1.di;
  endtask

  // One bus cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input port_t p0, input port_t p1);
    int g;
    port_t pg;
    @(negedge clk);
    drive(p0, p1);
    #1;
    g = model_grant(p0.req, p1.req);
    act_g0 = bus.P0_GNT; act_g1 = bus.P1_GNT;
    act_dv0 = bus.P0_DV; act_dv1 = bus.P1_DV;
    act_do0 = bus.P0_Do; act_do1 = bus.P1_Do;
    check("p0_gnt", 32'(bus.P0_GNT), 32'(g == 0));
    check("p1_gnt", 32'(bus.P1_GNT), 32'(g == 1));
    check("ram_en", 32'(bus.RAM_EN), 32'(g >= 0));
    if (g >= 0) begin
      pg = (g == 1) ? p1 : p0;
      check("ram_a", 32'(bus.RAM_A), 32'(pg.a));
      check("ram_we", 32'(bus.RAM_WE), 32'(pg.we));
      if (pg.we != 4'b0000) check("ram_di", bus.RAM_Di, pg.di);
    end else begin
      check("ram_we_idle", 32'(bus.RAM_WE), 32'd0);
    end
    check("p0_dv", 32'(bus.P0_DV), 32'(pend[0]));
    check("p1_dv", 32'(bus.P1_DV), 32'(pend[1]));
    if (pend[0]) check("p0_do", bus.P0_Do, pend_do[0]);
    if (pend[1]) check("p1_do", bus.P1_Do, pend_do[1]);
    @(posedge clk);
    model_update(g, p0, p1);
  endtask

  // Assert reset in the middle of a cycle that is granting, hold it across an edge, release idle.
  task automatic reset_during(input port_t p0, input port_t p1);
    int g;
    @(negedge clk);
    drive(p0, p1);
    #1;
    g = model_grant(p0.req, p1.req);
    check("pre_rst_p0_gnt", 32'(bus.P0_GNT), 32'(g == 0));
    check("pre_rst_p1_gnt", 32'(bus.P1_GNT), 32'(g == 1));
    rst_n = 1'b0;
    #1;
    check("rst_gnt", {30'd0, bus.P1_GNT, bus.P0_GNT}, 32'd0);
    check("rst_ram_en", 32'(bus.RAM_EN), 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    check("rst_dv", {30'd0, bus.P1_DV, bus.P0_DV}, 32'd0);
    check("rst_hold_gnt", {30'd0, bus.P1_GNT, bus.P0_GNT}, 32'd0);
    drive('0, '0);
    rst_n = 1'b1;
  endtask

  vec_t  vecs [15];
  port_t idle_p, p0l, p1r;
  bit    exp_p1 [8];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram_mem[i] = init_val(i);
      exp_mem[i] = init_val(i);
    end
    ram_mem[13'h1ABC] = 32'hDEADBEEF; exp_mem[13'h1ABC] = 32'hDEADBEEF;
    ram_mem[13'h0005] = 32'hFFFFFFFF; exp_mem[13'h0005] = 32'hFFFFFFFF;
    idle_p = '0;
    model_reset();

    // Reset holds all grants off even with both ports requesting.
    drive(mkp(1, 1, 0, 13'h1, 0), mkp(1, 1, 0, 13'h2, 0));
    @(negedge clk);
    #1;
    check("rst_gnt0", 32'(bus.P0_GNT), 32'd0);
    check("rst_gnt1", 32'(bus.P1_GNT), 32'd0);
    check("rst_en", 32'(bus.RAM_EN), 32'd0);
    check("rst_dv_init", {30'd0, bus.P1_DV, bus.P0_DV}, 32'd0);
    drive('0, '0);
    rst_n = 1'b1;

    vecs[0]  = '{mkp(1,0,0,13'h10,0), mkp(1,0,0,13'h20,0), 1, 0, -1, 32'h0};
    vecs[1]  = '{mkp(1,0,0,13'h11,0), mkp(1,0,0,13'h20,0), 0, 1,  0, init_val('h10)};
    vecs[2]  = '{mkp(1,0,0,13'h11,0), mkp(1,0,0,13'h21,0), 1, 0,  1, init_val('h20)};
    vecs[3]  = '{idle_p,              mkp(1,0,0,13'h21,0), 0, 1,  0, init_val('h11)};
    vecs[4]  = '{idle_p,              idle_p,              0, 0,  1, init_val('h21)};
    vecs[5]  = '{mkp(1,0,0,13'h1ABC,0), idle_p,            1, 0, -1, 32'h0};
    vecs[6]  = '{idle_p,              idle_p,              0, 0,  0, 32'hDEADBEEF};
    vecs[7]  = '{idle_p, mkp(1,0,4'b0101,13'h5,32'h11223344), 0, 1, -1, 32'h0};
    vecs[8]  = '{idle_p,              mkp(1,0,0,13'h5,0),  0, 1, -1, 32'h0};
    vecs[9]  = '{idle_p,              idle_p,              0, 0,  1, 32'hFF22FF44};
    vecs[10] = '{mkp(1,1,0,13'h30,0), mkp(1,0,0,13'h40,0), 1, 0, -1, 32'h0};
    vecs[11] = '{mkp(1,1,0,13'h30,0), mkp(1,0,0,13'h40,0), 1, 0,  0, init_val('h30)};
    vecs[12] = '{mkp(1,0,0,13'h30,0), mkp(1,0,0,13'h40,0), 1, 0,  0, init_val('h30)};
    vecs[13] = '{idle_p,              mkp(1,0,0,13'h40,0), 0, 1,  0, init_val('h30)};
    vecs[14] = '{idle_p,              idle_p,              0, 0,  1, init_val('h40)};

    foreach (vecs[i]) begin
      step(vecs[i].p0, vecs[i].p1);
      check($sformatf("vec%0d_gnt", i), {30'd0, act_g1, act_g0}, {30'd0, vecs[i].eg1, vecs[i].eg0});
      check($sformatf("vec%0d_dv", i), {30'd0, act_dv1, act_dv0},
            {30'd0, vecs[i].edv_port == 1, vecs[i].edv_port == 0});
      if (vecs[i].edv_port >= 0)
        check($sformatf("vec%0d_do", i), vecs[i].edv_port == 1 ? act_do1 : act_do0, vecs[i].edo);
    end

    // Permanent lock from P0 with P1 waiting: timeout hands P1 exactly one slot.
`ifdef ARB_LOCK_TIMEOUT_EN
    exp_p1 = '{0, 0, 0, 0, 1, 0, 0, 0};
`else
    exp_p1 = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    p0l = mkp(1, 1, 0, 13'h50, 0);
    p1r = mkp(1, 0, 0, 13'h60, 0);
    for (int i = 0; i < 8; i++) begin
      step(p0l, p1r);
      check($sformatf("lock_seq%0d_p1", i), 32'(act_g1), 32'(exp_p1[i]));
      check($sformatf("lock_seq%0d_p0", i), 32'(act_g0), 32'(!exp_p1[i]));
    end
    step(idle_p, p1r);
    check("lock_drop_no_gnt", {30'd0, act_g1, act_g0}, 32'd0);
    step(idle_p, p1r);
    check("lock_drop_p1", 32'(act_g1), 32'd1);
    step(idle_p, idle_p);

    // Reset mid-lock with a P1 read in flight, then reset on a P0 read-grant cycle.
    step(idle_p, mkp(1, 1, 0, 13'h70, 0));
    reset_during(mkp(1, 0, 0, 13'h71, 0), mkp(1, 1, 0, 13'h70, 0));
    step(idle_p, idle_p);
    step(mkp(1, 0, 0, 13'h72, 0), mkp(1, 0, 0, 13'h73, 0));
    check("post_rst_tie_p0", {30'd0, act_g1, act_g0}, 32'd1);
    step(mkp(1, 0, 0, 13'h74, 0), idle_p);
    reset_during(mkp(1, 0, 0, 13'h75, 0), idle_p);
    step(idle_p, idle_p);
    check("post_rst_no_dv", {30'd0, act_dv1, act_dv0}, 32'd0);
    step(mkp(1, 0, 0, 13'h76, 0), mkp(1, 0, 0, 13'h77, 0));
    check("post_rst2_tie_p0", {30'd0, act_g1, act_g0}, 32'd1);

    // Randomized traffic over a small address window so writes and reads collide.
    for (int i = 0; i < 400; i++) begin
      port_t r [2];
      for (int p = 0; p < 2; p++) begin
        r[p].req  = ($urandom_range(0, 3) != 0);
        r[p].lock = ($urandom_range(0, 3) == 0);
        r[p].we   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
        r[p].a    = 13'($urandom_range(0, 15));
        r[p].di   = $urandom;
      end
      if (i == 200) reset_during(r[0], r[1]);
      else          step(r[0], r[1]);
    end
    step(idle_p, idle_p);
    step(idle_p, idle_p);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_8kx32_arbiter.md
RAM_8KX32_ARBITER -- requirements
Module: ram_8kx32_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 16: maximum consecutive grants to one port while it holds a lock (range 2..255).
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RESETn  input  1  asynchronous, active-low reset.
REQ-004 Pp_REQ  input  1  access request from port p, p in {0,1}; held until granted.
REQ-005 Pp_LOCK  input  1  port p asks to keep ownership after this access.
REQ-006 Pp_WE  input  4  byte write enables; 4'b0000 means read.
REQ-007 Pp_A  input  13  word address.
REQ-008 Pp_Di  input  32  write data.
REQ-009 Pp_GNT  output  1  combinational; access accepted this cycle.
REQ-010 Pp_DV  output  1  registered; read data valid on Pp_Do this cycle.
REQ-011 Pp_Do  output  32  read data, equal to RAM_Do; meaningful only while Pp_DV=1.
REQ-012 RAM_EN, RAM_WE[3:0], RAM_A[12:0], RAM_Di[31:0]  output  to 8Kx32 RAM; combinational mux of the granted port.
REQ-013 RAM_Do  input  32  RAM read data, valid the cycle after an enabled read.

Function
REQ-014 At most one Pp_GNT SHALL be high per cycle; Pp_GNT=1 only if Pp_REQ=1.
REQ-015 A transfer completes in the cycle Pp_REQ and Pp_GNT are both high; RAM_EN=1 that cycle, otherwise RAM_EN=0 and RAM_WE=0.
REQ-016 FSM states: IDLE, OWN0, OWN1.
REQ-017 IDLE, one requester: grant it. Both requesting: grant the port not equal to register LAST. LAST SHALL be set to the granted port on every grant.
REQ-018 IDLE -> OWNp when port p is granted with Pp_LOCK=1.
REQ-019 OWNp: only port p may be granted. The other port's request is held off.
REQ-020 OWNp -> IDLE when port p is granted with Pp_LOCK=0, or when Pp_REQ=0. The other port becomes eligible in the next cycle, not the current one.
REQ-021 Read latency SHALL be exactly one cycle: a read granted in cycle N gives Pp_DV=1 for exactly cycle N+1, on the same port only.
REQ-022 Writes SHALL produce no DV pulse.
REQ-023 A new access may be granted in cycle N+1 while the DV of cycle N is being returned, giving full throughput of one access per cycle.
REQ-024 Address, data and WE SHALL pass unmodified. No address range checking (all 8192 words are valid).

Reset
REQ-025 While RESETn=0, and after release: state IDLE, LAST=1 (port 0 wins the first tie), P0_DV=P1_DV=0, lock counter=0.
REQ-026 While RESETn=0, all GNT outputs and RAM_EN SHALL be 0, regardless of requests.
REQ-027 Reset asserted mid-lock or with a read in flight SHALL drop the ownership and the pending DV. No DV pulse is emitted after release.

Configuration
REQ-028 Macro ARB_LOCK_TIMEOUT_EN.
REQ-029 Defined:
- An 8-bit counter counts consecutive grants in OWNp.
- On the LOCK_MAX-th grant, the FSM returns to IDLE regardless of Pp_LOCK.
- If the other port is requesting in the following cycle, it is granted first.
- The counter clears on entering IDLE.
REQ-030 Not defined: no counter exists, and a lock may be held indefinitely.

Verification
REQ-031 Solo read: P0 read A=0x1ABC (preloaded 0xDEADBEEF) -> P0_GNT same cycle, RAM_A=0x1ABC, P0_DV=1 with P0_Do=0xDEADBEEF next cycle, P1_DV stays 0.
REQ-032 Contention right after reset: both request every cycle for 4 cycles -> grants P0,P1,P0,P1; DV pulses alternate correctly.
REQ-033 Byte write then read: P1 WE=4'b0101, Di=0x11223344 to A=0x0005 over 0xFFFFFFFF -> P1 read returns 0xFF22FF44.
REQ-034 Lock: P0 holds LOCK for 3 grants, P1 requesting throughout -> P1 gets no grant until the cycle after the P0 grant with LOCK=0.
REQ-035 Timeout (macro defined, LOCK_MAX=4): P0 LOCK held permanently, P1 requesting -> P0 granted 4 cycles, then P1 granted, then P0. Macro undefined -> P1 never granted.
REQ-036 Reset at the read-grant cycle -> no DV after release; the next contended access grants P0.
